// File: rtl/execution_stage_muldiv_pkg.sv
// Shared definitions for the RV32IM execute stage.
//   - ALU opcode encodings (0-11 base integer, 16-23 M extension)
//   - FSM state encoding for the multi-cycle sequencer
//   - is_multicycle(): true for ops that go through the iterative unit
package execution_stage_muldiv_pkg;

  localparam logic [4:0] OpAdd    = 5'd0;
  localparam logic [4:0] OpSub    = 5'd1;
  localparam logic [4:0] OpSll    = 5'd2;
  localparam logic [4:0] OpSlt    = 5'd3;
  localparam logic [4:0] OpSltu   = 5'd4;
  localparam logic [4:0] OpXor    = 5'd5;
  localparam logic [4:0] OpSrl    = 5'd6;
  localparam logic [4:0] OpSra    = 5'd7;
  localparam logic [4:0] OpOr     = 5'd8;
  localparam logic [4:0] OpAnd    = 5'd9;
  localparam logic [4:0] OpLui    = 5'd10;
  localparam logic [4:0] OpAuipc  = 5'd11;
  localparam logic [4:0] OpMul    = 5'd16;
  localparam logic [4:0] OpMulh   = 5'd17;
  localparam logic [4:0] OpMulhsu = 5'd18;
  localparam logic [4:0] OpMulhu  = 5'd19;
  localparam logic [4:0] OpDiv    = 5'd20;
  localparam logic [4:0] OpDivu   = 5'd21;
  localparam logic [4:0] OpRem    = 5'd22;
  localparam logic [4:0] OpRemu   = 5'd23;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  // Divide/remainder always iterate; multiplies only without the fast multiplier.
  function automatic logic is_multicycle(input logic [4:0] op, input logic fast_mul);
    is_multicycle = (op[4:3] == 2'b10) && (op[2] || !fast_mul);
  endfunction

endpackage

// File: rtl/execution_stage_muldiv_iter.sv
// Iterative radix-2 multiply / restoring-divide core.
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_abort           drop the operation in flight
//   i_hold            freeze iteration
//   i_start           latch operands (magnitudes + signs) and begin XLEN steps
//   i_mop             M-op index: opcode - 16 (MUL..REMU)
//   i_a, i_b          raw operands
//   o_last            the final step happens on the coming edge
//   o_result          sign-corrected, op-selected result (valid once stepping is done)
module execution_stage_muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_abort,
  input  logic            i_hold,
  input  logic            i_start,
  input  logic [2:0]      i_mop,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic            r_run;
  logic [CntW-1:0] r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic [2:0]      r_mop;
  logic            r_sa, r_sb, r_bzero;

  // Operand signedness: MUL/MULH/DIV/REM signed both; MULHSU signed A only.
  logic w_sgn_a, w_sgn_b, w_sa, w_sb;
  assign w_sgn_a = i_mop[2] ? !i_mop[0] : (i_mop != 3'd3);
  assign w_sgn_b = i_mop[2] ? !i_mop[0] : !i_mop[1];
  assign w_sa    = w_sgn_a & i_a[XLEN-1];
  assign w_sb    = w_sgn_b & i_b[XLEN-1];

  // r_hi:r_lo is product (mul) or remainder:dividend/quotient (div).
  logic [XLEN:0] w_sum, w_shift, w_diff;
  assign w_sum   = {1'b0, r_hi} + {1'b0, r_b};
  assign w_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start && !i_hold) begin
      r_run   <= 1'b1;
      r_cnt   <= CntW'(XLEN);
      r_hi    <= '0;
      r_lo    <= w_sa ? -i_a : i_a;
      r_b     <= w_sb ? -i_b : i_b;
      r_sa    <= w_sa;
      r_sb    <= w_sb;
      r_bzero <= (i_b == '0);
      r_mop   <= i_mop;
    end else if (r_run && !i_hold) begin
      r_cnt <= r_cnt - CntW'(1);
      if (r_cnt == CntW'(1)) r_run <= 1'b0;
      if (!r_mop[2]) begin
        if (r_lo[0]) begin
          r_hi <= w_sum[XLEN:1];
          r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
        end else begin
          r_hi <= {1'b0, r_hi[XLEN-1:1]};
          r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
        end
      end else if (!w_diff[XLEN]) begin
        r_hi <= w_diff[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b1};
      end else begin
        r_hi <= w_shift[XLEN-1:0];
        r_lo <= {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  assign o_last = r_run && (r_cnt == CntW'(1)) && !i_hold;

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;
  assign w_prod = (r_sa ^ r_sb) ? -{r_hi, r_lo} : {r_hi, r_lo};
  // x/0 gives all-ones quotient regardless of sign; the remainder falls out
  // as the dividend naturally. MIN/-1 needs no special case either.
  assign w_quo  = r_bzero ? '1 : ((r_sa ^ r_sb) ? -r_lo : r_lo);
  assign w_rem  = r_sa ? -r_hi : r_hi;

  always_comb begin
    o_result = '0;
    case (r_mop)
      3'd0:                o_result = w_prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    o_result = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:          o_result = w_quo;
      default:             o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/execution_stage_muldiv.sv
// RV32IM execute stage with integrated EX/MEM pipeline register.
//   CLK, RST                   clock, synchronous active-high reset
//   STALL/CLEAR_EXECUTION_STAGE  hold outputs and FSM / flush with bubble
//   VALID_IN, PC_IN, RD_ADDRESS_IN, RS1_DATA, RS2_DATA, IMM_OUTPUT, OP_B_SELECT,
//   ALU_INSTRUCTION            instruction from decode
//   DATA_CACHE_*_IN, WRITE_BACK_MUX_SELECT_IN, RD_WRITE_ENABLE_IN  passed through
//   EXECUTION_BUSY             combinational stall request to the hazard unit
//   *_OUT                      registered EX/MEM outputs
module execution_stage_muldiv
  import execution_stage_muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FAST_MUL = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL_EXECUTION_STAGE,
  input  logic            CLEAR_EXECUTION_STAGE,
  input  logic            VALID_IN,
  input  logic [XLEN-1:0] PC_IN,
  input  logic [4:0]      RD_ADDRESS_IN,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic [XLEN-1:0] IMM_OUTPUT,
  input  logic            OP_B_SELECT,
  input  logic [4:0]      ALU_INSTRUCTION,
  input  logic [2:0]      DATA_CACHE_READ_IN,
  input  logic [1:0]      DATA_CACHE_WRITE_IN,
  input  logic            WRITE_BACK_MUX_SELECT_IN,
  input  logic            RD_WRITE_ENABLE_IN,
  output logic            EXECUTION_BUSY,
  output logic            VALID_OUT,
  output logic [4:0]      RD_ADDRESS_OUT,
  output logic [XLEN-1:0] ALU_OUT,
  output logic [2:0]      DATA_CACHE_READ_OUT,
  output logic [1:0]      DATA_CACHE_WRITE_OUT,
  output logic [XLEN-1:0] DATA_CACHE_WRITE_DATA_OUT,
  output logic            WRITE_BACK_MUX_SELECT_OUT,
  output logic            RD_WRITE_ENABLE_OUT
);

  localparam int unsigned ShW = $clog2(XLEN);

  state_e r_state;

  logic [XLEN-1:0] w_a, w_b, w_alu, w_core_res;
  logic [ShW-1:0]  w_shamt;
  logic            w_is_mc, w_start, w_last, w_load;

  assign w_a     = (ALU_INSTRUCTION == OpAuipc) ? PC_IN : RS1_DATA;
  assign w_b     = OP_B_SELECT ? IMM_OUTPUT : RS2_DATA;
  assign w_shamt = w_b[ShW-1:0];
  assign w_is_mc = is_multicycle(ALU_INSTRUCTION, FAST_MUL);
  assign w_start = (r_state == StIdle) && VALID_IN && w_is_mc;

  // Combinational multiplier; pruned when FAST_MUL=0.
  logic              w_fsa, w_fsb;
  logic [2*XLEN-1:0] w_fprod;
  assign w_fsa   = w_a[XLEN-1] && (ALU_INSTRUCTION != OpMulhu);
  assign w_fsb   = w_b[XLEN-1] && (ALU_INSTRUCTION == OpMul || ALU_INSTRUCTION == OpMulh);
  assign w_fprod = {{XLEN{w_fsa}}, w_a} * {{XLEN{w_fsb}}, w_b};

  always_comb begin
    w_alu = '0;
    case (ALU_INSTRUCTION)
      OpAdd:   w_alu = w_a + w_b;
      OpSub:   w_alu = w_a - w_b;
      OpSll:   w_alu = w_a << w_shamt;
      OpSlt:   w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      OpSltu:  w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
      OpXor:   w_alu = w_a ^ w_b;
      OpSrl:   w_alu = w_a >> w_shamt;
      OpSra:   w_alu = $signed(w_a) >>> w_shamt;
      OpOr:    w_alu = w_a | w_b;
      OpAnd:   w_alu = w_a & w_b;
      OpLui:   w_alu = w_b;
      OpAuipc: w_alu = w_a + w_b;
      OpMul:   w_alu = FAST_MUL ? w_fprod[XLEN-1:0] : '0;
      OpMulh, OpMulhsu, OpMulhu:
               w_alu = FAST_MUL ? w_fprod[2*XLEN-1:XLEN] : '0;
      default: w_alu = '0;
    endcase
  end

  execution_stage_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_abort (CLEAR_EXECUTION_STAGE),
    .i_hold  (STALL_EXECUTION_STAGE),
    .i_start (w_start),
    .i_mop   (ALU_INSTRUCTION[2:0]),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_last  (w_last),
    .o_result(w_core_res)
  );

  // Low in an unstalled FIX so decode advances on the retiring edge.
  assign EXECUTION_BUSY = VALID_IN && w_is_mc && !((r_state == StFix) && !STALL_EXECUTION_STAGE)
                          && !CLEAR_EXECUTION_STAGE;

  assign w_load = ((r_state == StIdle) && !w_start) || (r_state == StFix);

  always_ff @(posedge CLK) begin
    if (RST || CLEAR_EXECUTION_STAGE) begin
      r_state                   <= StIdle;
      VALID_OUT                 <= 1'b0;
      RD_ADDRESS_OUT            <= '0;
      ALU_OUT                   <= '0;
      DATA_CACHE_READ_OUT       <= '0;
      DATA_CACHE_WRITE_OUT      <= '0;
      DATA_CACHE_WRITE_DATA_OUT <= '0;
      WRITE_BACK_MUX_SELECT_OUT <= 1'b0;
      RD_WRITE_ENABLE_OUT       <= 1'b0;
    end else if (!STALL_EXECUTION_STAGE) begin
      unique case (r_state)
        StIdle: if (w_start) r_state <= StRun;
        StRun:  if (w_last) r_state <= StFix;
        StFix:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
      if (w_start) begin
        // Accept edge of a multi-cycle op: emit a bubble.
        VALID_OUT            <= 1'b0;
        RD_WRITE_ENABLE_OUT  <= 1'b0;
        DATA_CACHE_READ_OUT  <= '0;
        DATA_CACHE_WRITE_OUT <= '0;
      end else if (w_load) begin
        VALID_OUT                 <= VALID_IN;
        RD_ADDRESS_OUT            <= RD_ADDRESS_IN;
        ALU_OUT                   <= (r_state == StFix) ? w_core_res : w_alu;
        DATA_CACHE_READ_OUT       <= DATA_CACHE_READ_IN;
        DATA_CACHE_WRITE_OUT      <= DATA_CACHE_WRITE_IN;
        DATA_CACHE_WRITE_DATA_OUT <= RS2_DATA;
        WRITE_BACK_MUX_SELECT_OUT <= WRITE_BACK_MUX_SELECT_IN;
        RD_WRITE_ENABLE_OUT       <= RD_WRITE_ENABLE_IN;
      end
    end
  end

endmodule

// File: tb/tb_execution_stage_muldiv.sv
module tb_execution_stage_muldiv;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3,  SLTU = 5'd4;
  localparam logic [4:0] XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7,  OR = 5'd8,   AND = 5'd9;
  localparam logic [4:0] LUI = 5'd10, AUIPC = 5'd11;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22,    REMU = 5'd23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, clr, vin, bsel, wbs, rwe;
  logic [31:0] pc, rs1, rs2, imm;
  logic [4:0]  rd, op;
  logic [2:0]  dcr;
  logic [1:0]  dcw;

  logic        f_busy, f_vout, f_wbs, f_rwe, s_busy, s_vout, s_wbs, s_rwe;
  logic [4:0]  f_rd, s_rd;
  logic [31:0] f_alu, f_wd, s_alu, s_wd;
  logic [2:0]  f_dcr, s_dcr;
  logic [1:0]  f_dcw, s_dcw;

  execution_stage_muldiv #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (
    .CLK(clk), .RST(rst), .STALL_EXECUTION_STAGE(stall), .CLEAR_EXECUTION_STAGE(clr),
    .VALID_IN(vin), .PC_IN(pc), .RD_ADDRESS_IN(rd), .RS1_DATA(rs1), .RS2_DATA(rs2),
    .IMM_OUTPUT(imm), .OP_B_SELECT(bsel), .ALU_INSTRUCTION(op), .DATA_CACHE_READ_IN(dcr),
    .DATA_CACHE_WRITE_IN(dcw), .WRITE_BACK_MUX_SELECT_IN(wbs), .RD_WRITE_ENABLE_IN(rwe),
    .EXECUTION_BUSY(f_busy), .VALID_OUT(f_vout), .RD_ADDRESS_OUT(f_rd), .ALU_OUT(f_alu),
    .DATA_CACHE_READ_OUT(f_dcr), .DATA_CACHE_WRITE_OUT(f_dcw), .DATA_CACHE_WRITE_DATA_OUT(f_wd),
    .WRITE_BACK_MUX_SELECT_OUT(f_wbs), .RD_WRITE_ENABLE_OUT(f_rwe)
  );

  execution_stage_muldiv #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (
    .CLK(clk), .RST(rst), .STALL_EXECUTION_STAGE(stall), .CLEAR_EXECUTION_STAGE(clr),
    .VALID_IN(vin), .PC_IN(pc), .RD_ADDRESS_IN(rd), .RS1_DATA(rs1), .RS2_DATA(rs2),
    .IMM_OUTPUT(imm), .OP_B_SELECT(bsel), .ALU_INSTRUCTION(op), .DATA_CACHE_READ_IN(dcr),
    .DATA_CACHE_WRITE_IN(dcw), .WRITE_BACK_MUX_SELECT_IN(wbs), .RD_WRITE_ENABLE_IN(rwe),
    .EXECUTION_BUSY(s_busy), .VALID_OUT(s_vout), .RD_ADDRESS_OUT(s_rd), .ALU_OUT(s_alu),
    .DATA_CACHE_READ_OUT(s_dcr), .DATA_CACHE_WRITE_OUT(s_dcw), .DATA_CACHE_WRITE_DATA_OUT(s_wd),
    .WRITE_BACK_MUX_SELECT_OUT(s_wbs), .RD_WRITE_ENABLE_OUT(s_rwe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, imm, pc;
    logic        bsel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic set_vec(input int i, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic [31:0] p,
                         input logic bs, input logic [31:0] e);
    vecs[i].op = o; vecs[i].a = a; vecs[i].b = b; vecs[i].imm = im;
    vecs[i].pc = p; vecs[i].bsel = bs; vecs[i].exp = e;
  endtask

  task automatic set_instr(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; bsel = 1'b0; imm = 32'h0; pc = 32'h400;
    vin = 1'b1; rd = 5'd9; rwe = 1'b1; dcr = 3'd0; dcw = 2'd0; wbs = 1'b0;
  endtask

  // Drives one M-op and measures edges to VALID_OUT and BUSY cycles on both instances.
  task automatic run_mc(input string name, input logic [4:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat_f_exp, input int lat_s_exp);
    int lat_f, lat_s, busy_f, busy_s;
    logic [31:0] res_f, res_s;
    lat_f = 0; lat_s = 0; busy_f = 0; busy_s = 0; res_f = '0; res_s = '0;
    set_instr(o, a, b);
    for (int e = 1; e <= 60 && (lat_f == 0 || lat_s == 0); e++) begin
      #1;
      if (f_busy) busy_f++;
      if (s_busy) busy_s++;
      @(posedge clk);
      #1;
      if (lat_f == 0 && f_vout) begin lat_f = e; res_f = f_alu; end
      if (lat_s == 0 && s_vout) begin lat_s = e; res_s = s_alu; end
    end
    vin = 1'b0;
    chk({name, "_res_fast"}, res_f, exp);
    chk({name, "_res_iter"}, res_s, exp);
    chk({name, "_lat_fast"}, lat_f, lat_f_exp);
    chk({name, "_lat_iter"}, lat_s, lat_s_exp);
    chk({name, "_busy_fast"}, busy_f, lat_f_exp - 1);
    chk({name, "_busy_iter"}, busy_s, lat_s_exp - 1);
    tick();
  endtask

  initial begin
    int lat, hits;

    set_vec(0,  ADD,   32'd5,        32'd7,        32'h100,      32'h400,  1'b0, 32'd12);
    set_vec(1,  SRA,   32'h80000000, 32'h1F,       32'd4,        32'h400,  1'b1, 32'hF8000000);
    set_vec(2,  SUB,   32'd3,        32'd5,        32'h0,        32'h400,  1'b0, 32'hFFFFFFFE);
    set_vec(3,  SLL,   32'd1,        32'h21,       32'h0,        32'h400,  1'b0, 32'd2);
    set_vec(4,  SLT,   32'hFFFFFFFF, 32'd1,        32'h0,        32'h400,  1'b0, 32'd1);
    set_vec(5,  SLTU,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h400,  1'b0, 32'd0);
    set_vec(6,  XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h400,  1'b0, 32'h0FF00FF0);
    set_vec(7,  SRL,   32'h80000000, 32'd31,       32'h0,        32'h400,  1'b0, 32'd1);
    set_vec(8,  OR,    32'h12340000, 32'h00005678, 32'h0,        32'h400,  1'b0, 32'h12345678);
    set_vec(9,  AND,   32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        32'h400,  1'b0, 32'h0F000F00);
    set_vec(10, LUI,   32'hDEADBEEF, 32'd3,        32'hABCDE000, 32'h400,  1'b1, 32'hABCDE000);
    set_vec(11, 5'd12, 32'd5,        32'd7,        32'h0,        32'h400,  1'b0, 32'd0);
    set_vec(12, AUIPC, 32'h0000DEAD, 32'd3,        32'h2000,     32'h1000, 1'b1, 32'h3000);

    // Reset with random inputs.
    stall = 1'b0; clr = 1'b0; rst = 1'b1;
    vin = 1'b1; op = 5'($urandom_range(0, 23)); rs1 = $urandom; rs2 = $urandom;
    imm = $urandom; pc = $urandom; bsel = 1'($urandom); rd = 5'($urandom);
    dcr = 3'($urandom); dcw = 2'($urandom); wbs = 1'b1; rwe = 1'b1;
    tick();
    tick();
    chk("rst_ctrl_fast", {19'd0, f_vout, f_rd, f_dcr, f_dcw, f_wbs, f_rwe}, 32'd0);
    chk("rst_ctrl_iter", {19'd0, s_vout, s_rd, s_dcr, s_dcw, s_wbs, s_rwe}, 32'd0);
    chk("rst_alu_fast", f_alu, 32'd0);
    chk("rst_alu_iter", s_alu, 32'd0);
    chk("rst_wdata_fast", f_wd, 32'd0);
    chk("rst_wdata_iter", s_wd, 32'd0);
    rst = 1'b0; vin = 1'b0;
    #1;
    chk("rst_busy", {30'd0, f_busy, s_busy}, 32'd0);
    tick();

    // Single-cycle table.
    for (int i = 0; i < 13; i++) begin
      op = vecs[i].op; rs1 = vecs[i].a; rs2 = vecs[i].b; imm = vecs[i].imm;
      pc = vecs[i].pc; bsel = vecs[i].bsel; vin = 1'b1;
      rd = 5'(i + 1); dcr = 3'(i); dcw = 2'(i); wbs = i[0]; rwe = ~i[0];
      #1;
      chk($sformatf("vec%0d_busy", i), {30'd0, f_busy, s_busy}, 32'd0);
      tick();
      chk($sformatf("vec%0d_alu_fast", i), f_alu, vecs[i].exp);
      chk($sformatf("vec%0d_alu_iter", i), s_alu, vecs[i].exp);
      chk($sformatf("vec%0d_ctrl_fast", i), {19'd0, f_vout, f_rd, f_dcr, f_dcw, f_wbs, f_rwe},
          {19'd0, 1'b1, rd, dcr, dcw, wbs, rwe});
      chk($sformatf("vec%0d_wdata_iter", i), s_wd, rs2);
    end

    // Stall holds the registered outputs.
    stall = 1'b1; op = ADD; rs1 = 32'd1; rs2 = 32'd1; bsel = 1'b0; rd = 5'd30;
    tick();
    chk("stall_hold_alu", f_alu, 32'h3000);
    chk("stall_hold_rd", {27'd0, s_rd}, 32'd13);
    stall = 1'b0; vin = 1'b0;
    tick();

    // Multi-cycle ops: fast instance multiplies in 1 edge, everything else 34.
    run_mc("div_m7_2",   DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 34);
    run_mc("rem_m7_2",   REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 34);
    run_mc("divu_9_0",   DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 34, 34);
    run_mc("remu_9_0",   REMU,   32'd9,        32'd0,        32'd9,        34, 34);
    run_mc("div_m7_0",   DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 34, 34);
    run_mc("rem_m7_0",   REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 34, 34);
    run_mc("div_ovf",    DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 34);
    run_mc("rem_ovf",    REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        34, 34);
    run_mc("mulh_min",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1, 34);
    run_mc("mulhsu_m1",  MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 34);
    run_mc("mulhu_max",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 34);
    run_mc("mul_6_m7",   MUL,    32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6, 1, 34);

    // Accept edge emits a bubble after a valid ADD; then 3-cycle stall in RUN.
    set_instr(ADD, 32'd1, 32'd2);
    tick();
    set_instr(DIV, 32'd100, 32'd7);
    dcr = 3'd5; dcw = 2'd2;
    tick();
    chk("bubble_ctrl", {26'd0, s_vout, s_rwe, s_dcr, s_dcw}, 32'd0);
    tick();
    tick();
    stall = 1'b1;
    tick();
    tick();
    #1;
    chk("run_stall_busy", {31'd0, s_busy}, 32'd1);
    tick();
    chk("run_stall_vout", {31'd0, s_vout}, 32'd0);
    stall = 1'b0;
    lat = 6;
    while (!s_vout && lat < 60) begin
      tick();
      lat++;
    end
    chk("run_stall_lat", lat, 37);
    chk("run_stall_res_iter", s_alu, 32'd14);
    chk("run_stall_res_fast", {f_vout, f_alu[30:0]}, {1'b1, 31'd14});
    vin = 1'b0;
    tick();

    // Stall while in FIX keeps BUSY high and delays retirement.
    set_instr(DIV, 32'd100, 32'd7);
    for (int e = 0; e < 33; e++) tick();
    stall = 1'b1;
    #1;
    chk("fix_stall_busy", {30'd0, f_busy, s_busy}, 32'd3);
    tick();
    tick();
    chk("fix_stall_vout", {30'd0, f_vout, s_vout}, 32'd0);
    stall = 1'b0;
    #1;
    chk("fix_release_busy", {30'd0, f_busy, s_busy}, 32'd0);
    tick();
    chk("fix_release_vout", {30'd0, f_vout, s_vout}, 32'd3);
    chk("fix_release_res", s_alu, 32'd14);
    vin = 1'b0;
    tick();

    // Clear during RUN cycle 10 aborts; a following ADD retires in one edge.
    set_instr(DIV, 32'd100, 32'd7);
    for (int e = 0; e < 10; e++) tick();
    clr = 1'b1;
    #1;
    chk("clear_busy", {30'd0, f_busy, s_busy}, 32'd0);
    tick();
    clr = 1'b0;
    chk("clear_ctrl", {28'd0, f_vout, f_rwe, s_vout, s_rwe}, 32'd0);
    set_instr(ADD, 32'd1, 32'd2);
    tick();
    chk("clear_add_vout", {30'd0, f_vout, s_vout}, 32'd3);
    chk("clear_add_res", s_alu, 32'd3);
    vin = 1'b0;
    hits = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (f_vout || s_vout) hits++;
    end
    chk("clear_no_late_result", hits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
